// File: rtl/psd_mul_add_seq_pkg.sv
// Shared types and sizing for the shift-add multiply-accumulate slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package psd_mul_add_seq_pkg;

    localparam int PSD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } psd_state_t;

    // Counter must hold the value WIDTH itself, hence one bit beyond log2.
    function automatic int psd_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/psd_mul_add_seq_if.sv
// Operand/control/result bundle between a driver and the multiply-accumulate block.
// Latency: n/a (wiring only).
// Backpressure: none; start/stop are level-sampled pulses, no ready return path.
interface psd_mul_add_seq_if
    import psd_mul_add_seq_pkg::*;
#(
    parameter int WIDTH = PSD_WIDTH
);
    logic                 start;
    logic                 stop;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [WIDTH-1:0]     addend;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output start, stop, multiplicand, multiplier, addend,
        input  product, busy
    );

    modport slave (
        input  start, stop, multiplicand, multiplier, addend,
        output product, busy
    );
endinterface

// File: rtl/psd_mul_add_seq_step.sv
// One shift-add iteration: conditionally add mcand into the upper half, then shift right.
// Latency: purely combinational.
// Backpressure: n/a.
module psd_mul_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]  acc_cur,
    input  logic [WIDTH-1:0]  mcand,
    output logic [2*WIDTH:0]  acc_nxt
);
    // Upper half is WIDTH+1 bits so the adder carry survives until the shift.
    logic [WIDTH:0] hi_sum;

    assign hi_sum  = acc_cur[0] ? (acc_cur[2*WIDTH:WIDTH] + {1'b0, mcand})
                                : acc_cur[2*WIDTH:WIDTH];

    // Logical right shift of {hi_sum, lo}; the consumed multiplier bit falls off.
    assign acc_nxt = {1'b0, hi_sum, acc_cur[WIDTH-1:1]};

endmodule

// File: rtl/psd_mul_add_seq.sv
// Sequential multiply-accumulate: product = multiplicand*multiplier + addend, one bit per clock.
// Latency: start at edge N -> DONE after edge N+WIDTH; stop on a later edge loads product.
// Backpressure: none; start always (re)loads, stop is ignored while iterating.
module psd_mul_add_seq
    import psd_mul_add_seq_pkg::*;
#(
    parameter int WIDTH = PSD_WIDTH
) (
    input  logic              clock,
    input  logic              reset,
    psd_mul_add_seq_if.slave  bus
);
    localparam int CNT_W = psd_cnt_w(WIDTH);

    psd_state_t          state_q;
    psd_state_t          state_d;
    logic [CNT_W-1:0]    count_q;
    logic [2*WIDTH:0]    acc_q;
    logic [2*WIDTH:0]    acc_step;
    logic [WIDTH-1:0]    mcand_q;
    logic [2*WIDTH-1:0]  product_q;
    logic                last_step;

    assign last_step = (state_q == RUN) && (count_q == CNT_W'(1));

    psd_mul_step #(.WIDTH(WIDTH)) u_step (
        .acc_cur (acc_q),
        .mcand   (mcand_q),
        .acc_nxt (acc_step)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: start wins everywhere (restart), RUN exits on its final step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN: begin
                if (bus.start)      state_d = RUN;
                else if (last_step) state_d = DONE;
            end
            DONE:    if (bus.start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: busy mirrors the registered RUN state.
    always_comb begin
        bus.busy = (state_q == RUN);
    end

    // Datapath: load operands on start, otherwise iterate one multiplier bit per RUN cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            mcand_q <= '0;
            count_q <= '0;
        end else if (bus.start) begin
            acc_q   <= {1'b0, bus.addend, bus.multiplier};
            mcand_q <= bus.multiplicand;
            count_q <= CNT_W'(WIDTH);
        end else if (state_q == RUN) begin
            acc_q   <= acc_step;
            count_q <= count_q - CNT_W'(1);
        end
    end

    // Result register: only stop outside RUN may update it, so partial sums never escape.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                             product_q <= '0;
        else if (bus.stop && state_q != RUN)   product_q <= acc_q[2*WIDTH-1:0];
    end

    assign bus.product = product_q;

endmodule

// File: tb/tb_psd_mul_add_seq.sv
module tb_psd_mul_add_seq;
    localparam int W = 32;

    logic clock;
    logic reset;
    int   checks;
    int   passed;

    psd_mul_add_seq_if #(.WIDTH(W)) bus ();

    psd_mul_add_seq #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: plain 64-bit arithmetic.
    function automatic logic [63:0] ref_mac(input logic [31:0] mc, input logic [31:0] mp,
                                            input logic [31:0] ad);
        logic [63:0] a, b, c;
        a = {32'd0, mc};
        b = {32'd0, mp};
        c = {32'd0, ad};
        return a * b + c;
    endfunction

    task automatic start_op(input logic [31:0] mc, input logic [31:0] mp, input logic [31:0] ad);
        @(negedge clock);
        bus.start        = 1'b1;
        bus.multiplicand = mc;
        bus.multiplier   = mp;
        bus.addend       = ad;
        @(negedge clock);
        bus.start        = 1'b0;
    endtask

    // Counts negedges with busy high, bounded.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clock);
        end
    endtask

    task automatic pulse_stop();
        @(negedge clock);
        bus.stop = 1'b1;
        @(negedge clock);
        bus.stop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        bus.addend       = '0;
        #3;
        checks++;
        if (bus.product !== 64'd0) $display("FAIL reset_product got %h want 0", bus.product);
        else passed++;
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy);
        else passed++;
        @(negedge clock);
        reset = 1'b0;
        pulse_stop();
        checks++;
        if (bus.product !== 64'd0) $display("FAIL idle_stop got %h want 0", bus.product);
        else passed++;
    endtask

    task automatic test_vectors();
        logic [31:0] mc[3];
        logic [31:0] mp[3];
        logic [31:0] ad[3];
        logic [63:0] want[3];
        int cyc;
        mc[0] = 32'h0beefeba; mp[0] = 32'h00000001; ad[0] = 32'h064557be; want[0] = 64'h0000000012345678;
        mc[1] = 32'hffffffff; mp[1] = 32'hffffffff; ad[1] = 32'hffffffff; want[1] = 64'hffffffff00000000;
        mc[2] = 32'h0beefeba; mp[2] = 32'h00000000; ad[2] = 32'h00000000; want[2] = 64'd0;
        for (int i = 0; i < 3; i++) begin
            start_op(mc[i], mp[i], ad[i]);
            wait_done(cyc);
            checks++;
            if (cyc != W) $display("FAIL vec%0d_busy_cycles got %0d want %0d", i, cyc, W);
            else passed++;
            pulse_stop();
            checks++;
            if (bus.product !== want[i]) $display("FAIL vec%0d_product got %h want %h", i, bus.product, want[i]);
            else passed++;
        end
    endtask

    task automatic test_restart();
        int cyc;
        start_op(32'h12345678, 32'd1, 32'd0);
        repeat (9) @(negedge clock);
        start_op(32'd7, 32'd6, 32'd5);
        // Operands changing mid-run must not matter.
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
        bus.addend       = $urandom;
        wait_done(cyc);
        checks++;
        if (cyc != W) $display("FAIL restart_busy_cycles got %0d want %0d", cyc, W);
        else passed++;
        pulse_stop();
        checks++;
        if (bus.product !== 64'h2f) $display("FAIL restart_product got %h want 2f", bus.product);
        else passed++;
    endtask

    task automatic test_reset_abort();
        int cyc;
        start_op(32'd3, 32'd3, 32'd0);
        wait_done(cyc);
        pulse_stop();
        checks++;
        if (bus.product !== 64'd9) $display("FAIL abort_pre_product got %h want 9", bus.product);
        else passed++;
        start_op(32'd2, 32'd2, 32'd0);
        repeat (15) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.product !== 64'd0) $display("FAIL abort_product got %h want 0", bus.product);
        else passed++;
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.busy);
        else passed++;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL abort_stays_idle got %b want 0", bus.busy);
        else passed++;
        pulse_stop();
        checks++;
        if (bus.product !== 64'd0) $display("FAIL abort_later_stop got %h want 0", bus.product);
        else passed++;
    endtask

    task automatic test_stop_in_run();
        int cyc;
        logic [63:0] first;
        logic [63:0] second;
        first  = ref_mac(32'h00c0ffee, 32'h00001234, 32'h00000077);
        second = ref_mac(32'hdeadbeef, 32'h87654321, 32'h0badf00d);
        start_op(32'h00c0ffee, 32'h00001234, 32'h00000077);
        wait_done(cyc);
        pulse_stop();
        checks++;
        if (bus.product !== first) $display("FAIL runstop_first got %h want %h", bus.product, first);
        else passed++;
        start_op(32'hdeadbeef, 32'h87654321, 32'h0badf00d);
        repeat (19) @(negedge clock);
        bus.stop = 1'b1;
        @(negedge clock);
        bus.stop = 1'b0;
        checks++;
        if (bus.product !== first) $display("FAIL runstop_hold got %h want %h", bus.product, first);
        else passed++;
        wait_done(cyc);
        pulse_stop();
        checks++;
        if (bus.product !== second) $display("FAIL runstop_after got %h want %h", bus.product, second);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [63:0] a_res;
        logic [63:0] b_res;
        a_res = ref_mac(32'h13579bdf, 32'h2468ace0, 32'h11111111);
        b_res = ref_mac(32'h0000ffff, 32'hffff0000, 32'h00000001);
        start_op(32'h13579bdf, 32'h2468ace0, 32'h11111111);
        wait_done(cyc);
        // start and stop together: stop captures A, start begins B.
        bus.start        = 1'b1;
        bus.stop         = 1'b1;
        bus.multiplicand = 32'h0000ffff;
        bus.multiplier   = 32'hffff0000;
        bus.addend       = 32'h00000001;
        @(negedge clock);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        checks++;
        if (bus.product !== a_res) $display("FAIL b2b_first got %h want %h", bus.product, a_res);
        else passed++;
        checks++;
        if (bus.busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", bus.busy);
        else passed++;
        wait_done(cyc);
        checks++;
        if (cyc != W) $display("FAIL b2b_cycles got %0d want %0d", cyc, W);
        else passed++;
        pulse_stop();
        checks++;
        if (bus.product !== b_res) $display("FAIL b2b_second got %h want %h", bus.product, b_res);
        else passed++;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'hffffffff;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        int cyc;
        logic [31:0] mc, mp, ad;
        logic [63:0] want;
        for (int n = 0; n < 40; n++) begin
            mc = (n % 4 == 0) ? pick_operand() : $urandom;
            mp = (n % 4 == 1) ? pick_operand() : $urandom;
            ad = (n % 4 == 2) ? pick_operand() : $urandom;
            want = ref_mac(mc, mp, ad);
            start_op(mc, mp, ad);
            wait_done(cyc);
            checks++;
            if (cyc != W) $display("FAIL rand%0d_cycles got %0d want %0d", n, cyc, W);
            else passed++;
            pulse_stop();
            checks++;
            if (bus.product !== want) $display("FAIL rand%0d_product got %h want %h", n, bus.product, want);
            else passed++;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_vectors();
        test_restart();
        test_reset_abort();
        test_stop_in_run();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
